// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: chunk indexing and configuration check.
// ADDER_OVF_EN adds the operand-MSB skew lane used for the signed-overflow flag.
package adder_pkg;

`ifdef ADDER_OVF_EN
  localparam int unsigned MsbBits = 2;
`else
  localparam int unsigned MsbBits = 0;
`endif

  function automatic int unsigned stage_lo(input int unsigned k, input int unsigned chunk);
    return k * chunk;
  endfunction

  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/add_stage.sv
// One pipeline slot: CHUNK-bit adder, carry register, valid bit and the skew/deskew lane.
module add_stage #(
  parameter int unsigned CHUNK     = 8,
  parameter int unsigned LANE_BITS = 96
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adv_i,
  input  logic                 valid_i,
  input  logic [CHUNK-1:0]     a_i,
  input  logic [CHUNK-1:0]     b_i,
  input  logic                 carry_i,
  input  logic [LANE_BITS-1:0] lane_i,
  output logic                 valid_o,
  output logic [CHUNK-1:0]     sum_o,
  output logic                 carry_o,
  output logic [LANE_BITS-1:0] lane_o
);

  logic                 valid_q, valid_d;
  logic                 carry_q, carry_d;
  logic [CHUNK-1:0]     sum_q, sum_d;
  logic [LANE_BITS-1:0] lane_q, lane_d;
  logic [CHUNK:0]       add_res;

  always_comb begin
    add_res = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, carry_i};
    valid_d = valid_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    lane_d  = lane_q;
    if (adv_i) begin
      valid_d          = valid_i;
      {carry_d, sum_d} = add_res;
      lane_d           = lane_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      lane_q  <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      lane_q  <= lane_d;
    end
  end

  assign valid_o = valid_q;
  assign carry_o = carry_q;
  assign sum_o   = sum_q;
  assign lane_o  = lane_q;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined carry-chain adder: one CHUNK per stage, carry registered between stages.
// Define ADDER_OVF_EN to add the signed-overflow output ovf.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned Chunk    = WIDTH / STAGES;
  // Lane layout, MSB first: {a, b, finished sum, operand MSBs}
  localparam int unsigned LaneBits = 3 * WIDTH + MsbBits;
  localparam int unsigned SOff     = MsbBits;
  localparam int unsigned BOff     = MsbBits + WIDTH;
  localparam int unsigned AOff     = MsbBits + 2 * WIDTH;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic                             adv;
  logic [STAGES-1:0][Chunk-1:0]     a_ch, b_ch, s_q;
  logic [STAGES-1:0]                v_in, c_in, v_q, c_q;
  logic [STAGES-1:0][LaneBits-1:0]  lane_in, lane_out;

  always_comb begin
    adv      = out_ready | ~out_valid;
    in_ready = adv;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Lo = stage_lo(k, Chunk);

    if (k == 0) begin : g_head
      assign v_in[k] = in_valid;
      assign c_in[k] = cin;
      assign a_ch[k] = a[Chunk-1:0];
      assign b_ch[k] = b[Chunk-1:0];
`ifdef ADDER_OVF_EN
      assign lane_in[k] = {a, b, {WIDTH{1'b0}}, a[WIDTH-1], b[WIDTH-1]};
`else
      assign lane_in[k] = {a, b, {WIDTH{1'b0}}};
`endif
    end else begin : g_body
      assign v_in[k] = v_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign a_ch[k] = lane_out[k-1][AOff+Lo +: Chunk];
      assign b_ch[k] = lane_out[k-1][BOff+Lo +: Chunk];
      // The previous chunk's sum slot is still zero upstream, so OR-ing it in is exact.
      assign lane_in[k] = lane_out[k-1] | (LaneBits'(s_q[k-1]) << (SOff + Lo - Chunk));
    end

    add_stage #(
      .CHUNK    (Chunk),
      .LANE_BITS(LaneBits)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv_i  (adv),
      .valid_i(v_in[k]),
      .a_i    (a_ch[k]),
      .b_i    (b_ch[k]),
      .carry_i(c_in[k]),
      .lane_i (lane_in[k]),
      .valid_o(v_q[k]),
      .sum_o  (s_q[k]),
      .carry_o(c_q[k]),
      .lane_o (lane_out[k])
    );
  end

  assign out_valid = v_q[STAGES-1];
  assign carry     = c_q[STAGES-1];
  assign sum       = lane_out[STAGES-1][SOff +: WIDTH]
                   | (WIDTH'(s_q[STAGES-1]) << (WIDTH - Chunk));

  // Operand copies have no consumer past the last stage.
  logic unused_lane;
  assign unused_lane = ^lane_out[STAGES-1][LaneBits-1:BOff];

`ifdef ADDER_OVF_EN
  logic a_msb, b_msb;
  assign a_msb = lane_out[STAGES-1][1];
  assign b_msb = lane_out[STAGES-1][0];
  assign ovf   = (a_msb == b_msb) & (sum[WIDTH-1] != a_msb);
`endif

endmodule
